// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the seq_gen serial pattern transmitter.
// The optional LFSR background fill is enabled with SEQ_GEN_LFSR_FILL_EN.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int          WORD_W_DEF = 8;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 on a right-shifting register.
    localparam logic [15:0] LFSR_TAPS  = 16'h002D;

endpackage

// File: rtl/seq_gen_lfsr.sv
// 16-bit Fibonacci LFSR with enable and synchronous reset to the package seed.
// Used only when SEQ_GEN_LFSR_FILL_EN is defined.
module seq_gen_lfsr
    import seq_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: parallel words in over valid/ready, MSB-first bits out on x.
// Define SEQ_GEN_LFSR_FILL_EN to drive an LFSR background on x between payload words.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int   WORD_W   = WORD_W_DEF,
    parameter int   LEN_W    = 4,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              tst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              word_done,
    output state_e            dbg_state
);

    localparam logic [LEN_W-1:0] WORD_W_L = LEN_W'(WORD_W);
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);
    localparam logic [7:0]       GAP_L    = 8'(GAP);

    state_e            state, state_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [LEN_W-1:0]  cnt, cnt_n;
    logic [7:0]        gap_cnt, gap_n;
    logic              x_q, x_n;
    logic              fill_bit;
    logic              accept;
    logic              last_bit;
    logic [LEN_W-1:0]  len_c;
    logic [WORD_W-1:0] aligned;

`ifdef SEQ_GEN_LFSR_FILL_EN
    logic [15:0] lfsr_q;

    seq_gen_lfsr u_lfsr (
        .clk (clk),
        .rst (tst),
        .en  (state_n != ST_SHIFT),
        .q   (lfsr_q)
    );

    assign fill_bit = lfsr_q[0];
`else
    assign fill_bit = IDLE_BIT;
`endif

    // Handshake: a word is taken on the rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and in_data/in_len matter only at that edge.
    assign last_bit = (state == ST_SHIFT) && (cnt == ONE_L);
    assign in_ready = !tst && ((state == ST_IDLE) || (last_bit && (GAP == 0)));
    assign accept   = in_valid && in_ready;

    // Left-justify the payload so the first bit to send sits at the MSB.
    assign len_c   = (in_len > WORD_W_L) ? WORD_W_L : in_len;
    assign aligned = in_data << (WORD_W_L - len_c);

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        gap_n   = gap_cnt;
        x_n     = fill_bit;
        if (accept && (len_c != '0)) begin
            state_n = ST_SHIFT;
            x_n     = aligned[WORD_W-1];
            shreg_n = aligned << 1;
            cnt_n   = len_c;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (cnt == ONE_L) begin
                        cnt_n = '0;
                        if (GAP > 0) begin
                            state_n = ST_GAP;
                            gap_n   = GAP_L;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        x_n     = shreg[WORD_W-1];
                        shreg_n = shreg << 1;
                        cnt_n   = cnt - ONE_L;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= 8'd1) begin
                        state_n = ST_IDLE;
                        gap_n   = '0;
                    end else begin
                        gap_n = gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
            x_q     <= IDLE_BIT;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            gap_cnt <= gap_n;
            x_q     <= x_n;
        end
    end

    assign x         = x_q;
    assign x_valid   = (state == ST_SHIFT);
    assign busy      = (state != ST_IDLE);
    assign word_done = last_bit && !tst;
    assign dbg_state = state;

endmodule
